// File: rtl/systolic_pkg.sv
// systolic_pkg: shared defaults, feeder state encoding and the lane skew predicate.
package systolic_pkg;
    localparam int DEF_N      = 4;
    localparam int DEF_DATA_W = 8;
    typedef enum logic [1:0] {LOAD, STREAM, DONE} state_t;
    function automatic logic lane_active(int i, int t, int n);
        return i <= t && t < i + n;
    endfunction
endpackage

// File: rtl/feeder_tile_buf.sv
// feeder_tile_buf: one N x N tile of {A,B} operand pairs, written by beat index,
// read as N skewed lanes where lane i sees A[i][t-i] and B[t-i][i].
module feeder_tile_buf
    import systolic_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = $clog2(N*N),
    parameter int T_W    = $clog2(2*N-1)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IDX_W-1:0]    widx,
    input  logic [DATA_W-1:0]   wa,
    input  logic [DATA_W-1:0]   wb,
    input  logic [T_W-1:0]      t,
    output logic [N*DATA_W-1:0] a_rd,
    output logic [N*DATA_W-1:0] b_rd
);
    logic [2*DATA_W-1:0] mem [N*N];
    always_ff @(posedge clk)
        if (we) mem[widx] <= {wa, wb};
    // A walks along row i, B walks down column i; idle lanes read as zero
    always_comb begin
        a_rd = '0;
        b_rd = '0;
        for (int i = 0; i < N; i++)
            if (lane_active(i, int'(t), N)) begin
                a_rd[i*DATA_W +: DATA_W] = mem[IDX_W'(i*N + int'(t) - i)][DATA_W +: DATA_W];
                b_rd[i*DATA_W +: DATA_W] = mem[IDX_W'((int'(t) - i)*N + i)][DATA_W-1:0];
            end
    end
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers an N x N A/B tile and streams it diagonally skewed into a systolic array.
// Define SYSTOLIC_FEEDER_DOUBLE_BUF_EN for ping/pong buffers that load while the other tile streams.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = $clog2(N*N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [DATA_W-1:0]   ld_a,
    input  logic [DATA_W-1:0]   ld_b,
    input  logic                hold,
    output logic [N*DATA_W-1:0] a_edge,
    output logic [N*DATA_W-1:0] b_edge,
    output logic [N-1:0]        edge_vld,
    output logic                busy,
    output logic                done
);
    localparam int T_W = $clog2(2*N-1);
    localparam logic [T_W-1:0]   T_LAST = T_W'(2*N-2);
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N*N-1);
    state_t state, state_nx;
    logic [IDX_W-1:0] cnt;
    logic [T_W-1:0] t;
    logic [N*DATA_W-1:0] a_rd, b_rd;
    logic [N-1:0] vld;
    logic acc, last_beat, restart, emit;
    assign acc       = ld_valid && ld_ready;
    assign last_beat = acc && cnt == K_LAST;
    assign emit      = state == STREAM && !hold;
`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
    logic rd_sel, full, swap;
    logic [N*DATA_W-1:0] a_rd0, b_rd0, a_rd1, b_rd1;
    assign ld_ready = !full;
    assign restart  = full || last_beat;
    assign swap     = state_nx == STREAM && state != STREAM;
    assign a_rd     = rd_sel ? a_rd1 : a_rd0;
    assign b_rd     = rd_sel ? b_rd1 : b_rd0;
    feeder_tile_buf #(.N(N), .DATA_W(DATA_W), .IDX_W(IDX_W), .T_W(T_W)) u_buf0 (
        .clk, .we(acc && rd_sel), .widx(cnt), .wa(ld_a), .wb(ld_b), .t, .a_rd(a_rd0), .b_rd(b_rd0)
    );
    feeder_tile_buf #(.N(N), .DATA_W(DATA_W), .IDX_W(IDX_W), .T_W(T_W)) u_buf1 (
        .clk, .we(acc && !rd_sel), .widx(cnt), .wa(ld_a), .wb(ld_b), .t, .a_rd(a_rd1), .b_rd(b_rd1)
    );
    // loads always target the buffer not being streamed; a stream start flips the roles
    always_ff @(posedge clk)
        if (!rst) begin
            rd_sel <= 1'b0;
            full   <= 1'b0;
        end else begin
            rd_sel <= rd_sel ^ swap;
            full   <= swap ? 1'b0 : last_beat ? 1'b1 : full;
        end
`else
    assign ld_ready = state == LOAD;
    assign restart  = 1'b0;
    feeder_tile_buf #(.N(N), .DATA_W(DATA_W), .IDX_W(IDX_W), .T_W(T_W)) u_buf (
        .clk, .we(acc), .widx(cnt), .wa(ld_a), .wb(ld_b), .t, .a_rd, .b_rd
    );
`endif
    always_comb begin
        state_nx = state == LOAD   ? (last_beat ? STREAM : LOAD) :
                   state == STREAM ? (emit && t == T_LAST ? DONE : STREAM) :
                                     (restart ? STREAM : LOAD);
        vld = '0;
        for (int i = 0; i < N; i++) vld[i] = lane_active(i, int'(t), N);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= LOAD;
            cnt      <= '0;
            t        <= '0;
            a_edge   <= '0;
            b_edge   <= '0;
            edge_vld <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= !acc ? cnt : last_beat ? '0 : cnt + 1'b1;
            t        <= state != STREAM ? '0 : hold ? t : t + 1'b1;
            a_edge   <= emit ? a_rd : '0;
            b_edge   <= emit ? b_rd : '0;
            edge_vld <= emit ? vld : '0;
            busy     <= state == STREAM;
            done     <= state == DONE;
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed tiles; stimulus queues expected beats, a negedge monitor checks them.
module tb_systolic_feeder;
    localparam int N = 4, DW = 8;
    logic clk = 0, rst = 0, ld_valid = 0, hold = 0, mon_en = 0;
    logic ld_ready, busy, done;
    logic [DW-1:0] ld_a = 0, ld_b = 0;
    logic [N*DW-1:0] a_edge, b_edge;
    logic [N-1:0] edge_vld;
    int n_cmp = 0, n_bad = 0, cyc = 0;
    typedef struct packed {
        int cyc;
        logic [N-1:0] vld;
        logic [N*DW-1:0] a;
        logic [N*DW-1:0] b;
        logic dn;
    } item_t;
    item_t sb[$];
    logic [DW-1:0] mat_a [N*N];
    logic [DW-1:0] mat_b [N*N];

    systolic_feeder #(.N(N), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_a(ld_a), .ld_b(ld_b),
        .hold(hold), .a_edge(a_edge), .b_edge(b_edge), .edge_vld(edge_vld), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        item_t e;
        if (mon_en) begin
            if (edge_vld != 0 || done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out at cycle %0d: vld=%b done=%b expected nothing", cyc, edge_vld, done);
                end else begin
                    e = sb.pop_front();
                    check("beat_cycle", 64'(cyc), 64'(e.cyc));
                    check("edge_vld", 64'(edge_vld), 64'(e.vld));
                    check("a_edge", 64'(a_edge), 64'(e.a));
                    check("b_edge", 64'(b_edge), 64'(e.b));
                    check("done", 64'(done), 64'(e.dn));
                end
            end else
                check("idle_zero", {a_edge, b_edge}, 64'd0);
        end
    end

    task automatic fill(input int base_a, input int base_b, input bit flat);
        for (int k = 0; k < N*N; k++) begin
            mat_a[k] = DW'(flat ? base_a : base_a + k + 1);
            mat_b[k] = DW'(flat ? base_b : base_b + k + 1);
        end
    endtask

    task automatic load_tile(input int gap_at, input int gap_len, output int x);
        for (int k = 0; k < N*N; k++) begin
            if (k == gap_at) begin
                ld_valid = 0;
                repeat (gap_len) @(negedge clk);
            end
            ld_valid = 1;
            ld_a = mat_a[k];
            ld_b = mat_b[k];
            check("ld_ready", 64'(ld_ready), 64'd1);
            @(negedge clk);
        end
        ld_valid = 0;
        x = cyc;
    endtask

    task automatic push_tile(input int x, input int hold_at, input int hold_len, input int nb);
        item_t e;
        for (int t = 0; t < nb; t++) begin
            e = '0;
            e.cyc = x + 1 + t + (t >= hold_at ? hold_len : 0);
            for (int i = 0; i < N; i++)
                if (i <= t && t <= i + N - 1) begin
                    e.vld[i] = 1'b1;
                    e.a[i*DW +: DW] = mat_a[i*N + t - i];
                    e.b[i*DW +: DW] = mat_b[(t - i)*N + i];
                end
            sb.push_back(e);
        end
        if (nb == 2*N - 1) begin
            e = '0;
            e.cyc = x + 2*N + hold_len;
            e.dn = 1'b1;
            sb.push_back(e);
        end
    endtask

    task automatic drive_hold(input int x, input int at, input int len);
        while (cyc < x + at) @(negedge clk);
        hold = 1;
        repeat (len) @(negedge clk);
        hold = 0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a"}, 64'(a_edge), 64'd0);
        check({tag, "_b"}, 64'(b_edge), 64'd0);
        check({tag, "_vld"}, 64'(edge_vld), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_ready"}, 64'(ld_ready), 64'd1);
    endtask

    initial begin
        int x, y;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1;
        mon_en = 1;
        // single tile, ramp data
        fill(0, 16, 0);
        load_tile(99, 0, x);
        push_tile(x, 99, 0, 2*N-1);
`ifndef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
        ld_valid = 1;
        ld_a = 8'hff;
        ld_b = 8'hee;
        check("ld_ready_stream", 64'(ld_ready), 64'd0);
        @(negedge clk);
        check("busy_stream", 64'(busy), 64'd1);
        ld_valid = 0;
`endif
        drain(40);
        // load gap of 3 cycles at beat 5
        load_tile(5, 3, x);
        push_tile(x, 99, 0, 2*N-1);
        drain(40);
        // hold for 2 cycles at t=2
        load_tile(99, 0, x);
        push_tile(x, 2, 2, 2*N-1);
        drive_hold(x, 2, 2);
        drain(40);
        // reset while t=3 is pending
        load_tile(99, 0, x);
        push_tile(x, 99, 0, 3);
        while (cyc < x + 3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rst = 1;
        repeat (10) @(negedge clk);
        check("no_done_after_rst", 64'(sb.size()), 64'd0);
        // fresh flat tile
        fill(13, 11, 1);
        load_tile(99, 0, x);
        push_tile(x, 99, 0, 2*N-1);
        drain(40);
`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
        // tile 2 loads while tile 1 streams, stretched by a long hold
        fill(0, 16, 0);
        load_tile(99, 0, x);
        push_tile(x, 1, 12, 2*N-1);
        fill(100, 200, 0);
        push_tile(x + 20, 99, 0, 2*N-1);
        fork
            load_tile(99, 0, y);
            drive_hold(x, 1, 12);
        join
        drain(60);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Transmit-side partner of the PE grid. Buffers one N x N tile of A operands and one N x N tile of B operands.
- Streams them into the west edge (A, one lane per row) and the north edge (B, one lane per column) of an N x N systolic array of PE cells.
- Applies the diagonal skew the array needs: lane i is delayed i cycles.
- Sits between the operand loader and the PE array's a/b inputs.

Parameters:
- N, 4: array dimension; lane count per edge; tile is N*N words.
- DATA_W, 8: operand width; matches the PE a/b width.
- IDX_W, $clog2(N*N): load-beat counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- ld_valid  in  1  load beat offered.
- ld_ready  out  1  feeder accepts a load beat.
- ld_a  in  DATA_W  A[r][c] for the current beat.
- ld_b  in  DATA_W  B[r][c] for the current beat.
- hold  in  1  stall the stream (array back-pressure).
- a_edge  out  N*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W] and drives PE row i's a.
- b_edge  out  N*DATA_W  lane j drives PE column j's b.
- edge_vld  out  N  per-lane valid; the same vector qualifies both a_edge and b_edge.
- busy  out  1  high while in STREAM.
- done  out  1  one-cycle pulse after the final stream beat.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=LOAD, beat counter=0, t=0.
  - a_edge=0, b_edge=0, edge_vld=0, busy=0, done=0, ld_ready=1.
  - Buffer contents are don't-care.
  - Reset has priority over every other input in the same cycle.
- States: LOAD -> STREAM -> DONE -> LOAD.
- LOAD:
  - ld_ready=1. A beat is accepted when ld_valid && ld_ready.
  - Beat k stores A[k/N][k%N]=ld_a and B[k/N][k%N]=ld_b (row-major).
  - The accepted beat with k==N*N-1 moves the state to STREAM with t=0; the counter then wraps to 0.
  - hold is ignored in LOAD.
- STREAM:
  - ld_ready=0, busy=1. Step counter t runs 0..2N-2 (2N-1 beats).
  - All outputs are registered. The beat for step t appears the cycle after t is sampled with hold==0.
  - For lane i: edge_vld[i]=1 iff i<=t<=i+N-1.
  - When lane i is valid: a_edge lane i=A[i][t-i] and b_edge lane i=B[t-i][i]. Invalid lanes drive 0.
  - The first beat (t=0) is visible the cycle after the last load beat is accepted, unless hold is high in that cycle.
- hold in STREAM:
  - t does not advance.
  - Next-cycle outputs are all 0 and edge_vld=0.
  - The pending step is emitted intact after hold drops. No beat is skipped or duplicated.
- The last step (t=2N-2) is emitted, then the state moves to DONE.
- DONE: lasts exactly one cycle; done=1, busy=0, outputs 0; then LOAD.
- ld_valid outside LOAD is ignored and no data is captured (without the macro).
- Reset mid-LOAD or mid-STREAM aborts the tile. The next tile restarts at beat 0. No done pulse is generated.
- Data passes through unmodified; there is no arithmetic on operands.

Optional Feature:
- Macro: SYSTOLIC_FEEDER_DOUBLE_BUF_EN.
- Defined:
  - Two tile buffers (ping/pong). Loading into the idle buffer is allowed during STREAM and DONE.
  - ld_ready=1 whenever the idle buffer is not yet full.
  - If the idle buffer is full when DONE is reached, DONE is followed directly by STREAM on the swapped buffer, skipping LOAD.
  - Back-to-back tiles therefore have exactly one DONE cycle between stream bursts.
- Undefined:
  - A single buffer; behaviour is exactly as above.

Decomposition:
- Package systolic_pkg holds:
  - DATA_W and N defaults.
  - The state enum {LOAD, STREAM, DONE}.
  - A function lane_active(i,t) that returns i<=t && t<i+N.
- One sub-module, feeder_tile_buf:
  - N*N x 2*DATA_W register storage.
  - Write port indexed by beat number.
  - N parallel read ports indexed by (i, t-i).
  - Instantiated twice under the macro.

Test Plan:
- Single tile, N=4:
  - Stimulus: load A[r][c]=r*4+c+1 and B[r][c]=16+r*4+c+1, 16 beats, no hold.
  - Response: t=0 gives edge_vld=0001, a lane0=1, b lane0=17.
  - t=3 gives edge_vld=1111, a lanes0..3={4,7,10,13}, b lanes0..3={29,26,23,20}.
  - t=6 gives edge_vld=1000, a lane3=16, b lane3=32.
  - done pulses the following cycle.
- Load back-pressure:
  - Stimulus: drop ld_valid for 3 cycles at beat 5.
  - Response: no beat is lost; the stream is identical to the single-tile case.
- Hold mid-stream:
  - Stimulus: hold=1 for 2 cycles at t=2.
  - Response: two zero/invalid cycles, then t=2 is emitted; 7 valid beats total, done pulses 9 cycles after stream start.
- Reset mid-stream:
  - Stimulus: rst=0 at t=3.
  - Response: next cycle all outputs 0, ld_ready=1, no done; a fresh tile with A=13 and B=11 everywhere streams correctly.
- Ignored load:
  - Stimulus: ld_valid=1 during STREAM (macro off).
  - Response: ld_ready=0 and buffer contents unchanged.
- Macro on:
  - Stimulus: load tile 2 during tile 1's stream.
  - Response: tile 2's t=0 beat appears 2 cycles after tile 1's t=6 beat.
